// File: rtl/cpu_pkg.sv
// Shared definitions for the RV32 pipeline front end: fetch FSM states,
// bubble encoding, reset PC default, instruction field slice positions
// and small arithmetic helpers used by the fetch stage.
package cpu_pkg;

  // addi x0,x0,0 -- the canonical bubble
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Instruction field slice positions
  localparam int OP_LSB = 0;
  localparam int OP_MSB = 6;
  localparam int F3_LSB = 12;
  localparam int F3_MSB = 14;
  localparam int F7_LSB = 25;
  localparam int F7_MSB = 31;

  // Fetch-stage control states
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  // Word-align an address; redirect targets never trap on misalignment
  function automatic logic [31:0] align_word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  // Saturating 32-bit increment used by the optional performance counters
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      return v;
    end else begin
      return v + 32'd1;
    end
  endfunction

endpackage

// File: rtl/if_id_stage_pc_reg.sv
// Program counter register for the fetch stage. Holds the PC, produces
// PC+4 (wrapping modulo 2^32) and selects between redirect, advance and hold.
module pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_redirect_en,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_advance,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc4
);
  import cpu_pkg::*;

  logic [31:0] r_pc;
  logic [31:0] w_pc4;
  logic [31:0] w_pc_next;

  assign w_pc4 = r_pc + 32'd4;

  // Next-PC select: redirect beats advance, otherwise hold
  always_comb begin
    w_pc_next = r_pc;
    if (i_redirect_en) begin
      w_pc_next = align_word(i_redirect_pc);
    end else if (i_advance) begin
      w_pc_next = w_pc4;
    end else begin
      w_pc_next = r_pc;
    end
  end

  // PC register with asynchronous reset to the boot address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign o_pc  = r_pc;
  assign o_pc4 = w_pc4;

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID pipeline register for the 5-stage RV32 CPU.
// Owns the PC (via pc_reg), drives the instruction-memory address, latches
// the fetched word with its PC into the ID register and exposes the decode
// field slices. Handles stall, EX redirect and bubble insertion.
// Optional: define IF_PERF_CNT_EN to add saturating fetch/stall/flush counters.
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = cpu_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic [31:0] id_instr,
  output logic [6:0]  id_op,
  output logic [2:0]  id_funct3,
  output logic [6:0]  id_funct7
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_flush
`endif
);
  import cpu_pkg::*;

  fetch_state_t r_state;
  logic         r_id_valid;
  logic [31:0]  r_id_pc;
  logic [31:0]  r_id_pc4;
  logic [31:0]  r_id_instr;

  logic [31:0]  w_pc;
  logic [31:0]  w_pc4;
  logic         w_active;
  logic         w_redirect;
  logic         w_stall;
  logic         w_advance;

  // BOOT ignores stall and redirect; RUN/HOLD apply redirect > stall > advance
  assign w_active   = (r_state == RUN) || (r_state == HOLD);
  assign w_redirect = w_active && redirect_en;
  assign w_stall    = w_active && stall && !redirect_en;
  assign w_advance  = w_active && !stall && !redirect_en;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst           (rst),
    .i_redirect_en (w_redirect),
    .i_redirect_pc (redirect_pc),
    .i_advance     (w_advance),
    .o_pc          (w_pc),
    .o_pc4         (w_pc4)
  );

  // Fetch FSM and ID register: bubble on redirect, hold on stall, else capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= BOOT;
      r_id_valid <= 1'b0;
      r_id_instr <= NOP_INSTR;
      r_id_pc    <= 32'h0000_0000;
      r_id_pc4   <= 32'h0000_0004;
    end else begin
      case (r_state)
        BOOT: begin
          r_state <= RUN;
        end
        RUN, HOLD: begin
          if (redirect_en) begin
            r_state    <= RUN;
            r_id_valid <= 1'b0;
            r_id_instr <= NOP_INSTR;
          end else if (stall) begin
            r_state <= HOLD;
          end else begin
            r_state    <= RUN;
            r_id_valid <= 1'b1;
            r_id_instr <= imem_rdata;
            r_id_pc    <= w_pc;
            r_id_pc4   <= w_pc4;
          end
        end
        default: begin
          r_state    <= BOOT;
          r_id_valid <= 1'b0;
          r_id_instr <= NOP_INSTR;
        end
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;

  // Saturating event counters for fetches, honoured stalls and flushes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_fetch <= 32'h0000_0000;
      r_perf_stall <= 32'h0000_0000;
      r_perf_flush <= 32'h0000_0000;
    end else begin
      if (w_advance) begin
        r_perf_fetch <= sat_inc(r_perf_fetch);
      end
      if (w_stall) begin
        r_perf_stall <= sat_inc(r_perf_stall);
      end
      if (w_redirect) begin
        r_perf_flush <= sat_inc(r_perf_flush);
      end
    end
  end

  assign perf_fetch = r_perf_fetch;
  assign perf_stall = r_perf_stall;
  assign perf_flush = r_perf_flush;
`endif

  assign imem_addr = w_pc;
  assign id_valid  = r_id_valid;
  assign id_pc     = r_id_pc;
  assign id_pc4    = r_id_pc4;
  assign id_instr  = r_id_instr;
  assign id_op     = r_id_instr[OP_MSB:OP_LSB];
  assign id_funct3 = r_id_instr[F3_MSB:F3_LSB];
  assign id_funct7 = r_id_instr[F7_MSB:F7_LSB];

endmodule
